// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: EX/MEM consumer, data-memory req/ack handshake, MEM/WB register.
// Optional WAIT timeout with sticky error is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] exmem_ALU,
  input  logic [15:0] exmem_RD1,
  input  logic [15:0] exmem_R0,
  input  logic [3:0]  exmem_wAddr,
  input  logic        exmem_muxWB,
  input  logic        exmem_memRead,
  input  logic        exmem_memWrite,
  input  logic        exmem_regWrite,
  input  logic        exmem_regWrite0,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic [15:0] memwb_rdata,
  output logic [15:0] memwb_ALU,
  output logic [15:0] memwb_R0,
  output logic [3:0]  memwb_wAddr,
  output logic        memwb_muxWB,
  output logic        memwb_regWrite,
  output logic        memwb_regWrite0
);

  localparam int unsigned CW = 8;

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT must be in 1..255");
  end

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state, state_n;
  logic   mem_op_c;
  logic   wb_load_c;
  logic   issue_c;
  logic   done_c;
  logic   abort_c;
  logic   tmo_c;

  assign mem_op_c = exmem_memRead | exmem_memWrite;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state, stall and datapath strobes
  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    wb_load_c = 1'b0;
    issue_c   = 1'b0;
    done_c    = 1'b0;
    abort_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op_c) begin
          stall   = 1'b1;
          issue_c = 1'b1;
          state_n = ST_WAIT;
        end else begin
          wb_load_c = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          wb_load_c = 1'b1;
          done_c    = 1'b1;
          state_n   = ST_IDLE;
        end else if (tmo_c) begin
          abort_c = 1'b1;
          state_n = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // Memory request port; held stable for the whole WAIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
    end else if (issue_c) begin
      mem_req   <= 1'b1;
      mem_we    <= exmem_memWrite;
      mem_addr  <= exmem_ALU;
      mem_wdata <= exmem_RD1;
    end else if (done_c || abort_c) begin
      mem_req   <= 1'b0;
    end
  end

  // MEM/WB register: real fields on completion, bubble otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memwb_rdata     <= 16'h0000;
      memwb_ALU       <= 16'h0000;
      memwb_R0        <= 16'h0000;
      memwb_wAddr     <= 4'h0;
      memwb_muxWB     <= 1'b0;
      memwb_regWrite  <= 1'b0;
      memwb_regWrite0 <= 1'b0;
    end else if (wb_load_c) begin
      memwb_rdata     <= (done_c && !mem_we) ? mem_rdata : 16'h0000;
      memwb_ALU       <= exmem_ALU;
      memwb_R0        <= exmem_R0;
      memwb_wAddr     <= exmem_wAddr;
      memwb_muxWB     <= exmem_muxWB;
      memwb_regWrite  <= exmem_regWrite;
      memwb_regWrite0 <= exmem_regWrite0;
    end else begin
      memwb_rdata     <= 16'h0000;
      memwb_ALU       <= 16'h0000;
      memwb_R0        <= 16'h0000;
      memwb_wAddr     <= 4'h0;
      memwb_muxWB     <= 1'b0;
      memwb_regWrite  <= 1'b0;
      memwb_regWrite0 <= 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [CW-1:0] wait_cnt;

  // wait_cnt holds completed WAIT cycles; the current cycle is number wait_cnt+1
  assign tmo_c = (state == ST_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (issue_c)                wait_cnt <= '0;
      else if (state == ST_WAIT)  wait_cnt <= wait_cnt + CW'(1);
      if (abort_c)                mem_err  <= 1'b1;
    end
  end
`else
  assign tmo_c   = 1'b0;
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl; MEM/WB expectations go through a scoreboard queue.
module tb_mem_stage_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] exmem_ALU, exmem_RD1, exmem_R0;
  logic [3:0]  exmem_wAddr;
  logic        exmem_muxWB, exmem_memRead, exmem_memWrite, exmem_regWrite, exmem_regWrite0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall, mem_err;
  logic [15:0] memwb_rdata, memwb_ALU, memwb_R0;
  logic [3:0]  memwb_wAddr;
  logic        memwb_muxWB, memwb_regWrite, memwb_regWrite0;

  typedef struct packed {
    logic [15:0] rdata;
    logic [15:0] alu;
    logic [15:0] r0;
    logic [3:0]  waddr;
    logic        muxwb;
    logic        rw;
    logic        rw0;
  } wb_t;

  wb_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .exmem_ALU(exmem_ALU), .exmem_RD1(exmem_RD1), .exmem_R0(exmem_R0),
    .exmem_wAddr(exmem_wAddr), .exmem_muxWB(exmem_muxWB),
    .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
    .exmem_regWrite(exmem_regWrite), .exmem_regWrite0(exmem_regWrite0),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .mem_err(mem_err),
    .memwb_rdata(memwb_rdata), .memwb_ALU(memwb_ALU), .memwb_R0(memwb_R0),
    .memwb_wAddr(memwb_wAddr), .memwb_muxWB(memwb_muxWB),
    .memwb_regWrite(memwb_regWrite), .memwb_regWrite0(memwb_regWrite0)
  );

  always #5 clock = ~clock;

  function automatic wb_t cur_wb();
    return '{memwb_rdata, memwb_ALU, memwb_R0, memwb_wAddr,
             memwb_muxWB, memwb_regWrite, memwb_regWrite0};
  endfunction

  task automatic set_nop();
    exmem_ALU = 16'h0; exmem_RD1 = 16'h0; exmem_R0 = 16'h0; exmem_wAddr = 4'h0;
    exmem_muxWB = 1'b0; exmem_memRead = 1'b0; exmem_memWrite = 1'b0;
    exmem_regWrite = 1'b0; exmem_regWrite0 = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    wb_t got;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
    set_nop();
    exmem_memRead = 1'b1;
    step(); step();
    #2;
    got = cur_wb();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b exp 0", stall); end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_err !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: req=%b we=%b err=%b exp 0 0 0", mem_req, mem_we, mem_err);
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      failures++; $display("FAIL reset_addr: addr=%h wdata=%h exp 0000 0000", mem_addr, mem_wdata);
    end
    checks++;
    if (got !== wb_t'(0)) begin failures++; $display("FAIL reset_memwb: got %h exp 0", got); end
    set_nop();
    step();
    reset = 1'b0;
  endtask

  task automatic test_alu_op();
    wb_t got;
    exmem_ALU = 16'h1234; exmem_wAddr = 4'd3; exmem_regWrite = 1'b1; exmem_R0 = 16'h0055;
    exp_q.push_back('{16'h0, 16'h1234, 16'h0055, 4'd3, 1'b0, 1'b1, 1'b0});
    #3;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall: got %b exp 0", stall); end
    step();
    set_nop();
    got = cur_wb();
    checks++;
    if (got !== exp_q[0]) begin failures++; $display("FAIL alu_memwb: got %h exp %h", got, exp_q[0]); end
    void'(exp_q.pop_front());
    #2;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall_after: got %b exp 0", stall); end
  endtask

  // Issues one load/store; ack arrives after ack_dly unacknowledged WAIT cycles
  task automatic run_mem_op(input string name, input logic [15:0] addr, input logic [15:0] wd,
                            input logic rd, input logic wr, input logic [3:0] wa,
                            input int ack_dly, input logic [15:0] rdata);
    wb_t got;
    int  stalls = 0;
    exmem_ALU = addr; exmem_RD1 = wd; exmem_R0 = addr ^ 16'h0F0F; exmem_wAddr = wa;
    exmem_muxWB = rd; exmem_memRead = rd; exmem_memWrite = wr;
    exmem_regWrite = 1'b1; exmem_regWrite0 = 1'b1;
    exp_q.push_back('{(wr ? 16'h0 : rdata), addr, addr ^ 16'h0F0F, wa, rd, 1'b1, 1'b1});
    for (int i = 0; i <= ack_dly + 1; i++) begin
      mem_ack   = (i == ack_dly + 1);
      mem_rdata = mem_ack ? rdata : 16'hDEAD;
      #3;
      if (stall === 1'b1) stalls++;
      if (i == 1) begin
        got = cur_wb();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== wr) begin
          failures++; $display("FAIL %s_req: req=%b we=%b exp 1 %b", name, mem_req, mem_we, wr);
        end
        checks++;
        if (mem_addr !== addr || mem_wdata !== wd) begin
          failures++; $display("FAIL %s_addr: addr=%h wdata=%h exp %h %h", name, mem_addr, mem_wdata, addr, wd);
        end
        checks++;
        if (got !== wb_t'(0)) begin failures++; $display("FAIL %s_bubble: got %h exp 0", name, got); end
      end
      step();
    end
    mem_ack = 1'b0;
    set_nop();
    got = cur_wb();
    checks++;
    if (stalls != ack_dly + 1) begin failures++; $display("FAIL %s_stalls: got %0d exp %0d", name, stalls, ack_dly + 1); end
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL %s_req_clear: got %b exp 0", name, mem_req); end
    checks++;
    if (got !== exp_q[0]) begin failures++; $display("FAIL %s_memwb: got %h exp %h", name, got, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_load();
    run_mem_op("load", 16'h0040, 16'h7777, 1'b1, 1'b0, 4'd5, 3, 16'hBEEF);
  endtask

  task automatic test_store();
    run_mem_op("store", 16'h0010, 16'hA5A5, 1'b0, 1'b1, 4'd0, 0, 16'h1357);
  endtask

  task automatic test_both();
    run_mem_op("both", 16'h0020, 16'h5A5A, 1'b1, 1'b1, 4'd7, 1, 16'h2468);
  endtask

  task automatic test_back_to_back();
    run_mem_op("b2b_a", 16'h0100, 16'h0001, 1'b1, 1'b0, 4'd1, 0, 16'hC0DE);
    run_mem_op("b2b_b", 16'h0102, 16'h0002, 1'b0, 1'b1, 4'd2, 2, 16'hFACE);
  endtask

  task automatic test_idle_ack();
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    #3;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL idle_ack_stall: got %b exp 0", stall); end
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || memwb_rdata !== 16'h0) begin
      failures++; $display("FAIL idle_ack: req=%b rdata=%h exp 0 0000", mem_req, memwb_rdata);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int  stalls = 0;
    bit  dropped = 0;
    wb_t got;
    exmem_ALU = 16'h0080; exmem_memRead = 1'b1; exmem_regWrite = 1'b1; exmem_wAddr = 4'd9;
    mem_ack = 1'b0;
    for (int i = 0; i < 12 && !dropped; i++) begin
      #3;
      if (stall === 1'b1) stalls++;
      else dropped = 1;
      if (dropped) begin
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL tmo_req_held: got %b exp 1", mem_req); end
      end
      step();
    end
    set_nop();
    got = cur_wb();
    checks++;
    if (!dropped || stalls != 4) begin failures++; $display("FAIL tmo_stalls: got %0d exp 4", stalls); end
    checks++;
    if (mem_req !== 1'b0 || mem_err !== 1'b1) begin
      failures++; $display("FAIL tmo_abort: req=%b err=%b exp 0 1", mem_req, mem_err);
    end
    checks++;
    if (got !== wb_t'(0)) begin failures++; $display("FAIL tmo_bubble: got %h exp 0", got); end
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || mem_err !== 1'b1 || memwb_rdata !== 16'h0) begin
      failures++; $display("FAIL tmo_late_ack: req=%b err=%b rdata=%h exp 0 1 0000", mem_req, mem_err, memwb_rdata);
    end
  endtask
`else
  task automatic test_no_err();
    checks++;
    if (mem_err !== 1'b0) begin failures++; $display("FAIL no_err: got %b exp 0", mem_err); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    wb_t got;
    exmem_ALU = 16'h0200; exmem_memRead = 1'b1; exmem_regWrite = 1'b1; exmem_muxWB = 1'b1;
    mem_ack = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_req_pre: got %b exp 1", mem_req); end
    step();
    #1;
    reset = 1'b1;
    #1;
    got = cur_wb();
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rst_mid: req=%b stall=%b exp 0 0", mem_req, stall);
    end
    checks++;
    if (got !== wb_t'(0)) begin failures++; $display("FAIL rst_mid_memwb: got %h exp 0", got); end
    set_nop();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_after: got %b exp 0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_both();
    test_back_to_back();
    test_idle_ack();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left: got %0d exp 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller: the consumer end of the EX/MEM pipeline buffer. It takes the registered EX/MEM fields, runs a request/acknowledge handshake to data memory for loads and stores, stalls upstream stages while an access is outstanding, and registers the MEM/WB fields for write-back. It sits between the EX/MEM buffer and the write-back mux/register file in the 5-stage CPU.

## Interface
- TIMEOUT, 15: maximum WAIT cycles without `mem_ack` before an abort (only with `MEM_TIMEOUT_EN`); legal range 1..255.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- exmem_ALU  in  16  ALU result / memory address.
- exmem_RD1  in  16  store data.
- exmem_R0  in  16  R0 value passed through.
- exmem_wAddr  in  4  destination register.
- exmem_muxWB, exmem_memRead, exmem_memWrite, exmem_regWrite, exmem_regWrite0  in  1 each  EX/MEM control fields.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req` = 1.
- mem_addr  out  16  captured address.
- mem_wdata  out  16  captured store data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  16  read data, valid when `mem_ack` = 1.
- stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- mem_err  out  1  sticky timeout flag.
- memwb_rdata, memwb_ALU, memwb_R0  out  16 each  MEM/WB data fields.
- memwb_wAddr  out  4  MEM/WB destination register.
- memwb_muxWB, memwb_regWrite, memwb_regWrite0  out  1 each  MEM/WB control fields.

## Operation
- States: IDLE and WAIT.
- IDLE, no memory op (`exmem_memRead` = `exmem_memWrite` = 0):
  - `stall` = 0.
  - Next edge loads MEM/WB from the EX/MEM fields, with `memwb_rdata` = 0.
- IDLE, memory op:
  - `stall` = 1.
  - Next edge captures `exmem_ALU` into `mem_addr` and `exmem_RD1` into `mem_wdata`.
  - Same edge sets `mem_we` = `exmem_memWrite`, `mem_req` = 1, and goes to WAIT.
  - Same edge loads MEM/WB with a bubble: all MEM/WB outputs 0.
- Both `exmem_memRead` and `exmem_memWrite` set: treated as a write (`mem_we` = 1).
- WAIT, `mem_ack` = 0:
  - `stall` = 1; `mem_req`, `mem_addr`, `mem_wdata` and `mem_we` are held.
  - Each edge loads a bubble into MEM/WB.
- WAIT, `mem_ack` = 1:
  - `stall` = 0.
  - Next edge loads MEM/WB from the EX/MEM fields.
  - `memwb_rdata` = `mem_rdata` for a read, 0 for a write.
  - Same edge clears `mem_req` and returns to IDLE.
- `mem_ack` while in IDLE is ignored.
- Reset mid-access: `mem_req` drops immediately; the pending access is abandoned.

## Timing
- Reset values: `mem_req`, `mem_we` and `mem_err` = 0; `mem_addr` and `mem_wdata` = 16'h0000; all memwb_* outputs = 0; state = IDLE.
- `stall` during reset = 0.
- Non-memory instruction: MEM/WB updated 1 edge after it appears on EX/MEM.
- Memory instruction:
  - `mem_req` rises 1 edge after the op appears on EX/MEM.
  - `mem_ack` may arrive in the first WAIT cycle.
  - Minimum latency is 2 edges, with 1 stall cycle.
  - Stall cycles = 1 + the number of WAIT cycles without ack.
- Back-to-back memory ops: the second op appears on EX/MEM in the cycle after the ack edge. From there it follows the IDLE-with-memory-op path (IDLE → WAIT); no WAIT → WAIT shortcut.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter counts WAIT cycles.
  - When it reaches TIMEOUT with no ack, `stall` = 0 in that cycle.
  - Next edge clears `mem_req`, loads a bubble into MEM/WB, sets `mem_err` = 1 (held until reset) and returns to IDLE.
  - The counter clears on entry to WAIT.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal completion, no error.
- `MEM_TIMEOUT_EN` undefined: WAIT lasts indefinitely, `mem_err` is tied to 0 and no counter is synthesized.

## Test plan
- Reset asserted mid-WAIT → `mem_req` = 0 immediately; all memwb_* outputs = 0; `stall` = 0.
- ALU op: ALU = 16'h1234, wAddr = 3, regWrite = 1 → next edge `memwb_ALU` = 16'h1234, `memwb_wAddr` = 3, `memwb_regWrite` = 1, `memwb_rdata` = 0, `stall` = 0 throughout.
- Load, addr 16'h0040; `mem_ack` 3 cycles after `mem_req` with `mem_rdata` = 16'hBEEF:
  - `stall` high for exactly 4 cycles.
  - `mem_addr` = 16'h0040 and `mem_we` = 0 while `mem_req` = 1.
  - `memwb_rdata` = 16'hBEEF one edge after the ack.
- Store, addr 16'h0010, RD1 = 16'hA5A5; ack in first WAIT cycle → `mem_we` = 1, `mem_wdata` = 16'hA5A5, 1 stall cycle, `memwb_rdata` = 0.
- Both memRead and memWrite set → `mem_we` = 1.
- With `MEM_TIMEOUT_EN`, TIMEOUT = 4, no ack:
  - `stall` is high for 4 cycles and drops in the cycle the counter reaches 4.
  - `mem_req` clears and `mem_err` = 1 after the next edge; MEM/WB is a bubble.
  - A later ack in IDLE is ignored.
